combine: RTL
============

# combine

Sample-stream combiner for the flow library: the inverse of `split`. Takes one N-word vector per `in_nd` strobe on a concatenated bus and re-serialises it into a single WDTH-bit stream, one word per cycle, lowest slice first. An internal vector FIFO absorbs bursts that arrive faster than one vector per N cycles. Sits after parallel per-stream processing to rebuild an interleaved sample stream.

## Interface
- `N`, 2: number of words per input vector (N ≥ 1).
- `WDTH`, 32: word width in bits.
- `LOG_DEPTH`, 2: FIFO holds DEPTH = 2^LOG_DEPTH queued vectors, not counting the one being emitted.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  N*WDTH  input vector; word k = `in_data[(k+1)*WDTH-1 : k*WDTH]`.
- `in_nd`  in  1  new-data strobe; vector valid in any cycle it is high.
- `out_data`  out  WDTH  serialised word, registered.
- `out_nd`  out  1  `out_data` valid this cycle, registered.
- `error`  out  1  sticky overflow flag, registered.

## Operation
- FIFO: DEPTH entries of N*WDTH bits, write pointer, read pointer, occupancy `count` from 0 to DEPTH. Pointers wrap modulo DEPTH.
- Output stage: shift register of N*WDTH bits, word index `idx` from 0 to N-1, state IDLE or EMIT.
- Write: at an edge with `in_nd`=1, the vector is pushed if `count` < DEPTH, or if a pop occurs at the same edge. Otherwise the vector is dropped and `error` is set to 1; it holds until reset.
- Pop/load happens at an edge where `count` > 0 and either state = IDLE, or state = EMIT with `idx` = N-1. On a pop/load:
  - the head vector moves to the shift register; `idx`←0; state←EMIT;
  - `out_data`←word 0; `out_nd`←1.
- In EMIT with `idx` < N-1: `idx`←`idx`+1, `out_data`←next word, `out_nd`←1.
- In EMIT with `idx` = N-1 and `count` = 0: state←IDLE, `out_nd`←0. `out_data` holds its last value.
- Push and pop at the same edge: `count` is unchanged; both pointers advance.
- Word order: word 0 (LSB slice) first, word N-1 last. This matches the `split` convention in which stream 0 is the lowest slice.
- N=1: every vector is loaded and emitted in one cycle; `idx` stays 0.
- Reset, asserted at any time including mid-vector:
  - `out_data`=0, `out_nd`=0, `error`=0;
  - `count`=0, pointers=0, `idx`=0, state=IDLE;
  - all queued and in-flight vectors are discarded.

## Timing
- Latency: `in_nd` high in cycle c with the FIFO empty and state IDLE → word 0 appears with `out_nd`=1 in cycle c+2, and word k in cycle c+2+k.
- Output is gap-free across vectors: if the next vector is queued, its word 0 follows the previous word N-1 in the next cycle.
- Sustained throughput: one vector per N cycles. Extra vectors queue up to DEPTH; total buffering is DEPTH+1 vectors including the one being emitted.
- `out_nd` has no back-pressure; downstream must accept every word.
- `error` rises in the cycle after the edge that drops a vector.

## Test plan
- **Single vector.** N=2, WDTH=32; `in_data`={32'hBBBB0002, 32'hAAAA0001} with `in_nd` for one cycle at c → `out_data`=32'hAAAA0001 at c+2 and 32'hBBBB0002 at c+3, `out_nd` high exactly those two cycles, `error`=0.
- **Paced stream.** N=2; one vector every 2 cycles for 20 vectors → continuous `out_nd`, 40 words in order, no gaps after the first, `count` never above 1.
- **Burst fill.** N=4, LOG_DEPTH=2; 5 vectors on consecutive cycles, values 0..19 → 20 consecutive words 0..19 with no gaps; `error`=0 because DEPTH+1 = 5 vectors fit.
- **Overflow.** Same configuration with 7 consecutive vectors → the 6th is accepted because it coincides with a pop; the 7th is dropped; `error`=1 from the next cycle and stays high; output contains vectors 1–6 only.
- **Reset mid-vector.** N=4; deassert `rst_n` asynchronously while word 1 is on the output → `out_nd`=0 and `out_data`=0 immediately. After release, no stale words appear, and a new vector emerges at its normal c+2 latency.
- **N=1 pass-through.** WDTH=16; `in_nd` every cycle with an incrementing value → identical stream delayed by 2 cycles, `error`=0.

Source files
------------

// File: rtl/combine.sv
// Vector-to-stream combiner: queues N-word vectors in a small FIFO and
// re-emits them one WDTH-bit word per cycle, lowest slice first.
module combine #(
    parameter int N         = 2,
    parameter int WDTH      = 32,
    parameter int LOG_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*WDTH-1:0] in_data,
    input  logic              in_nd,
    output logic [WDTH-1:0]   out_data,
    output logic              out_nd,
    output logic              error
);

    localparam int DEPTH = 1 << LOG_DEPTH;
    localparam int VW    = N * WDTH;
    localparam int IDXW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [VW-1:0]        mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr, rd_ptr;
    logic [LOG_DEPTH:0]   count;
    logic [VW-1:0]        shift;
    logic [IDXW-1:0]      idx;
    state_t               state;

    logic last_word, pop, push;

    // A pop frees a slot at the same edge, so a full FIFO can still accept.
    always_comb begin
        last_word = (idx == IDXW'(N - 1));
        pop       = (count != '0) && ((state == IDLE) || last_word);
        push      = in_nd && ((count < (LOG_DEPTH+1)'(DEPTH)) || pop);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            shift    <= '0;
            idx      <= '0;
            state    <= IDLE;
            out_data <= '0;
            out_nd   <= 1'b0;
            error    <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + LOG_DEPTH'(1);

            case ({push, pop})
                2'b10:   count <= count + (LOG_DEPTH+1)'(1);
                2'b01:   count <= count - (LOG_DEPTH+1)'(1);
                default: count <= count;
            endcase

            if (in_nd && !push)
                error <= 1'b1;

            // The shift register keeps the not-yet-emitted words, next word in the low slice.
            if (pop) begin
                rd_ptr   <= rd_ptr + LOG_DEPTH'(1);
                out_data <= mem[rd_ptr][WDTH-1:0];
                shift    <= mem[rd_ptr] >> WDTH;
                idx      <= '0;
                state    <= EMIT;
                out_nd   <= 1'b1;
            end else if (state == EMIT && !last_word) begin
                out_data <= shift[WDTH-1:0];
                shift    <= shift >> WDTH;
                idx      <= idx + IDXW'(1);
                out_nd   <= 1'b1;
            end else if (state == EMIT) begin
                state  <= IDLE;
                out_nd <= 1'b0;
            end
        end
    end

endmodule
